matmul_ext: RTL and testbench

MATMUL_EXT -- requirements
Module: matmul_ext

---
 rtl/matmul_ext.sv | 272 +++++++++++++++++++++++++++
 tb/tb_matmul_ext.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_ext.sv
// matmul_ext: memory-to-memory integer matrix multiply, C = A*B or C = C + A*B, over one shared memory port.
// Latency: each read costs issue + grant + rvalid cycles and each write issue + grant; done pulses once after the last write.
// Backpressure: one transaction in flight; the request is held stable until mem_gnt, and reads wait for mem_rvalid.
module matmul_ext #(
  parameter int DIM_BITS = 16,
  parameter int MEM_AW   = 16,
  parameter int MEM_DW   = 32,
  parameter int PREC     = 16,
  parameter int ACC_W    = 40
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                go,
  input  logic [MEM_AW-1:0]   aBASE,
  input  logic [MEM_AW-1:0]   bBASE,
  input  logic [MEM_AW-1:0]   cBASE,
  input  logic [DIM_BITS-1:0] aROWS,
  input  logic [DIM_BITS-1:0] aCOLS,
  input  logic [DIM_BITS-1:0] bCOLS,
  input  logic [DIM_BITS-1:0] aSTRIDE,
  input  logic [DIM_BITS-1:0] bSTRIDE,
  input  logic [DIM_BITS-1:0] cSTRIDE,
  input  logic                signed_mode,
  input  logic                accum_mode,
  input  logic [5:0]          out_shift,
  output logic                mem_req,
  output logic                mem_write,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [MEM_DW-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [MEM_DW-1:0]   mem_rdata,
  output logic                busy,
  output logic                done,
  output logic                sat_flag
);

  typedef enum logic [3:0] {
    S_IDLE, S_ROW, S_COL, S_RDC, S_RDA, S_RDB, S_MAC, S_WR, S_DONE
  } state_t;

  localparam logic [DIM_BITS-1:0] D_ONE = DIM_BITS'(1);
  localparam logic [MEM_AW-1:0]   A_ONE = MEM_AW'(1);

  state_t state_q, state_d;

  // configuration captured when a run starts
  logic [DIM_BITS-1:0] a_rows_q, a_rows_d, a_cols_q, a_cols_d, b_cols_q, b_cols_d;
  logic [DIM_BITS-1:0] a_stride_q, a_stride_d, b_stride_q, b_stride_d, c_stride_q, c_stride_d;
  logic [MEM_AW-1:0]   b_base_q, b_base_d;
  logic                signed_q, signed_d, accum_q, accum_d;
  logic [5:0]          shift_q, shift_d;

  // loop counters and running addresses (row starts, current element pointers)
  logic [DIM_BITS-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [MEM_AW-1:0]   a_row_q, a_row_d, c_row_q, c_row_d, b_col_q, b_col_d;
  logic [MEM_AW-1:0]   a_ptr_q, a_ptr_d, b_ptr_q, b_ptr_d, c_ptr_q, c_ptr_d;

  // datapath
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [PREC-1:0]     op_a_q, op_a_d, op_b_q, op_b_d;

  // memory port and status
  logic                mem_req_q, mem_req_d, mem_write_q, mem_write_d, pend_q, pend_d;
  logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
  logic [MEM_DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic                busy_q, busy_d, done_q, done_d, sat_q, sat_d;

  logic [MEM_AW-1:0]   rd_addr;
  logic [ACC_W-1:0]    shifted;
  logic [ACC_W:0]      shx;
  logic [MEM_DW-1:0]   wb_val;
  logic                wb_sat;

  function automatic logic [ACC_W-1:0] ext_op(input logic [PREC-1:0] v, input logic sgn);
    if (sgn) ext_op = ACC_W'($signed(v));
    else     ext_op = ACC_W'(v);
  endfunction

  function automatic logic [ACC_W-1:0] ext_word(input logic [MEM_DW-1:0] v, input logic sgn);
    if (sgn) ext_word = ACC_W'($signed(v));
    else     ext_word = ACC_W'(v);
  endfunction

  // writeback value: shift the accumulator, then clamp to the memory word range
  always_comb begin
    if (signed_q) shifted = $signed(acc_q) >>> shift_q;
    else          shifted = acc_q >> shift_q;
    // one extra top bit so the range test also works when ACC_W == MEM_DW
    shx    = {signed_q & shifted[ACC_W-1], shifted};
    wb_val = shifted[MEM_DW-1:0];
    wb_sat = 1'b0;
    if (signed_q) begin
      if (shx[ACC_W:MEM_DW-1] != {(ACC_W-MEM_DW+2){shx[ACC_W]}}) begin
        wb_sat = 1'b1;
        wb_val = shx[ACC_W] ? {1'b1, {(MEM_DW-1){1'b0}}} : {1'b0, {(MEM_DW-1){1'b1}}};
      end
    end else if (|shx[ACC_W:MEM_DW]) begin
      wb_sat = 1'b1;
      wb_val = '1;
    end
  end

  // read address for whichever read state is active
  always_comb begin
    rd_addr = a_ptr_q;
    if (state_q == S_RDC)      rd_addr = c_ptr_q;
    else if (state_q == S_RDB) rd_addr = b_ptr_q;
  end

  // next-state, counters, datapath and memory handshake
  always_comb begin
    state_d     = state_q;
    a_rows_d    = a_rows_q;   a_cols_d   = a_cols_q;   b_cols_d   = b_cols_q;
    a_stride_d  = a_stride_q; b_stride_d = b_stride_q; c_stride_d = c_stride_q;
    b_base_d    = b_base_q;   signed_d   = signed_q;   accum_d    = accum_q;
    shift_d     = shift_q;
    i_d         = i_q;        j_d        = j_q;        k_d        = k_q;
    a_row_d     = a_row_q;    c_row_d    = c_row_q;    b_col_d    = b_col_q;
    a_ptr_d     = a_ptr_q;    b_ptr_d    = b_ptr_q;    c_ptr_d    = c_ptr_q;
    acc_d       = acc_q;      op_a_d     = op_a_q;     op_b_d     = op_b_q;
    mem_req_d   = mem_req_q;  mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q; mem_wdata_d = mem_wdata_q;
    pend_d      = pend_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    sat_d       = sat_q;

    case (state_q)
      S_IDLE: begin
        if (go) begin
          a_rows_d   = aROWS;   a_cols_d   = aCOLS;   b_cols_d   = bCOLS;
          a_stride_d = aSTRIDE; b_stride_d = bSTRIDE; c_stride_d = cSTRIDE;
          b_base_d   = bBASE;   signed_d   = signed_mode; accum_d = accum_mode;
          shift_d    = out_shift;
          i_d        = '0;
          a_row_d    = aBASE;
          c_row_d    = cBASE;
          busy_d     = 1'b1;
          sat_d      = 1'b0;
          state_d    = S_ROW;
        end
      end
      S_ROW: begin
        if (i_q != a_rows_q) begin
          j_d     = '0;
          b_col_d = b_base_q;
          c_ptr_d = c_row_q;
          state_d = S_COL;
        end else begin
          state_d = S_DONE;
        end
      end
      S_COL: begin
        if (j_q != b_cols_q) begin
          acc_d   = '0;
          k_d     = '0;
          a_ptr_d = a_row_q;
          b_ptr_d = b_col_q;
          if (accum_q)                state_d = S_RDC;
          else if (a_cols_q == '0)    state_d = S_WR;
          else                        state_d = S_RDA;
        end else begin
          i_d     = i_q + D_ONE;
          a_row_d = a_row_q + MEM_AW'(a_stride_q);
          c_row_d = c_row_q + MEM_AW'(c_stride_q);
          state_d = S_ROW;
        end
      end
      S_RDC, S_RDA, S_RDB: begin
        if (!mem_req_q && !pend_q) begin
          mem_req_d   = 1'b1;
          mem_write_d = 1'b0;
          mem_addr_d  = rd_addr;
        end else if (mem_req_q) begin
          if (mem_gnt) begin
            mem_req_d = 1'b0;
            pend_d    = 1'b1;
          end
        end else if (mem_rvalid) begin
          pend_d = 1'b0;
          if (state_q == S_RDC) begin
            acc_d   = ext_word(mem_rdata, signed_q);
            state_d = (a_cols_q == '0) ? S_WR : S_RDA;
          end else if (state_q == S_RDA) begin
            op_a_d  = mem_rdata[PREC-1:0];
            state_d = S_RDB;
          end else begin
            op_b_d  = mem_rdata[PREC-1:0];
            state_d = S_MAC;
          end
        end
      end
      S_MAC: begin
        acc_d = acc_q + ext_op(op_a_q, signed_q) * ext_op(op_b_q, signed_q);
        if (k_q + D_ONE != a_cols_q) begin
          k_d     = k_q + D_ONE;
          a_ptr_d = a_ptr_q + A_ONE;
          b_ptr_d = b_ptr_q + MEM_AW'(b_stride_q);
          state_d = S_RDA;
        end else begin
          state_d = S_WR;
        end
      end
      S_WR: begin
        if (!mem_req_q) begin
          // acc is frozen in this state, so wb_val stays stable until the grant
          mem_req_d   = 1'b1;
          mem_write_d = 1'b1;
          mem_addr_d  = c_ptr_q;
          mem_wdata_d = wb_val;
          if (wb_sat) sat_d = 1'b1;
        end else if (mem_gnt) begin
          mem_req_d   = 1'b0;
          mem_write_d = 1'b0;
          j_d         = j_q + D_ONE;
          b_col_d     = b_col_q + A_ONE;
          c_ptr_d     = c_ptr_q + A_ONE;
          state_d     = S_COL;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state register; reset clears every flop, including mid-transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      a_rows_q   <= '0; a_cols_q   <= '0; b_cols_q   <= '0;
      a_stride_q <= '0; b_stride_q <= '0; c_stride_q <= '0;
      b_base_q   <= '0; signed_q   <= 1'b0; accum_q  <= 1'b0;
      shift_q    <= '0;
      i_q        <= '0; j_q        <= '0; k_q        <= '0;
      a_row_q    <= '0; c_row_q    <= '0; b_col_q    <= '0;
      a_ptr_q    <= '0; b_ptr_q    <= '0; c_ptr_q    <= '0;
      acc_q      <= '0; op_a_q     <= '0; op_b_q     <= '0;
      mem_req_q  <= 1'b0; mem_write_q <= 1'b0;
      mem_addr_q <= '0; mem_wdata_q <= '0;
      pend_q     <= 1'b0;
      busy_q     <= 1'b0; done_q   <= 1'b0; sat_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_rows_q   <= a_rows_d;   a_cols_q   <= a_cols_d;   b_cols_q   <= b_cols_d;
      a_stride_q <= a_stride_d; b_stride_q <= b_stride_d; c_stride_q <= c_stride_d;
      b_base_q   <= b_base_d;   signed_q   <= signed_d;   accum_q    <= accum_d;
      shift_q    <= shift_d;
      i_q        <= i_d;        j_q        <= j_d;        k_q        <= k_d;
      a_row_q    <= a_row_d;    c_row_q    <= c_row_d;    b_col_q    <= b_col_d;
      a_ptr_q    <= a_ptr_d;    b_ptr_q    <= b_ptr_d;    c_ptr_q    <= c_ptr_d;
      acc_q      <= acc_d;      op_a_q     <= op_a_d;     op_b_q     <= op_b_d;
      mem_req_q  <= mem_req_d;  mem_write_q <= mem_write_d;
      mem_addr_q <= mem_addr_d; mem_wdata_q <= mem_wdata_d;
      pend_q     <= pend_d;
      busy_q     <= busy_d;     done_q     <= done_d;     sat_q      <= sat_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_matmul_ext.sv
// tb_matmul_ext: directed runs of matmul_ext against a word-addressed memory model.
// Expected transactions are queued at stimulus time; a memory-side monitor pops them on every grant.
// Grant and rvalid delays are optional random stalls of 0-5 cycles.
module tb_matmul_ext;

  logic        clk = 1'b0;
  logic        rst_n, go;
  logic [15:0] aBASE, bBASE, cBASE, aROWS, aCOLS, bCOLS, aSTRIDE, bSTRIDE, cSTRIDE;
  logic        signed_mode, accum_mode;
  logic [5:0]  out_shift;
  logic        mem_req, mem_write, mem_gnt, mem_rvalid;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        busy, done, sat_flag;

  always #5 clk = ~clk;

  matmul_ext dut (
    .clk(clk), .rst_n(rst_n), .go(go),
    .aBASE(aBASE), .bBASE(bBASE), .cBASE(cBASE),
    .aROWS(aROWS), .aCOLS(aCOLS), .bCOLS(bCOLS),
    .aSTRIDE(aSTRIDE), .bSTRIDE(bSTRIDE), .cSTRIDE(cSTRIDE),
    .signed_mode(signed_mode), .accum_mode(accum_mode), .out_shift(out_shift),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .sat_flag(sat_flag)
  );

  typedef struct packed {
    logic        w;
    logic [15:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] wv_q[$];
  logic [31:0] mem [0:65535];
  int          n_chk = 0;
  int          n_pass = 0;
  int          done_cnt = 0;
  int          n_rd = 0;
  bit          stall_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic fail(input string name, input string msg);
    n_chk++;
    $display("FAIL %s: %s", name, msg);
  endtask

  // memory model and scoreboard monitor
  initial begin : monitor
    int          gwait, rwait;
    bit          rd_pend, held;
    logic [15:0] rd_addr;
    txn_t        hold_v, a, e;
    gwait = 0; rwait = 0; rd_pend = 0; held = 0; rd_addr = '0; hold_v = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_gnt = 0;
      mem_rvalid = 0;
      if (done) done_cnt++;
      if (rd_pend) begin
        if (rwait == 0) begin
          mem_rvalid = 1;
          mem_rdata  = mem[rd_addr];
          rd_pend    = 0;
        end else rwait--;
      end else if (mem_req) begin
        a = '{w: mem_write, addr: mem_addr, data: (mem_write ? mem_wdata : 32'h0)};
        if (held) chk("req_stable", a, hold_v);
        if (gwait == 0) begin
          mem_gnt = 1;
          held    = 0;
          gwait   = stall_en ? int'($urandom_range(5, 0)) : 0;
          if (exp_q.size() == 0) begin
            fail("unexpected_txn", $sformatf("w=%0d addr=0x%0h data=0x%0h", a.w, a.addr, a.data));
          end else begin
            e = exp_q.pop_front();
            chk("txn", a, e);
          end
          if (mem_write) mem[mem_addr] = mem_wdata;
          else begin
            rd_pend = 1;
            rd_addr = mem_addr;
            rwait   = stall_en ? int'($urandom_range(5, 0)) : 0;
            n_rd++;
          end
        end else begin
          gwait--;
          if (!held) begin
            held   = 1;
            hold_v = a;
          end
        end
      end
    end
  end

  task automatic cfg(input logic [15:0] ab, bb, cb, m, k, n, as, bs, cs,
                     input logic sm, am, input logic [5:0] sh);
    aBASE = ab; bBASE = bb; cBASE = cb;
    aROWS = m; aCOLS = k; bCOLS = n;
    aSTRIDE = as; bSTRIDE = bs; cSTRIDE = cs;
    signed_mode = sm; accum_mode = am; out_shift = sh;
  endtask

  // queue the expected read/write sequence; write data comes from hand values in wv_q
  task automatic push_gemm();
    logic [15:0] ad;
    for (int i = 0; i < int'(aROWS); i++) begin
      for (int j = 0; j < int'(bCOLS); j++) begin
        if (accum_mode) begin
          ad = 16'(int'(cBASE) + i * int'(cSTRIDE) + j);
          exp_q.push_back('{w: 1'b0, addr: ad, data: 32'h0});
        end
        for (int k = 0; k < int'(aCOLS); k++) begin
          ad = 16'(int'(aBASE) + i * int'(aSTRIDE) + k);
          exp_q.push_back('{w: 1'b0, addr: ad, data: 32'h0});
          ad = 16'(int'(bBASE) + k * int'(bSTRIDE) + j);
          exp_q.push_back('{w: 1'b0, addr: ad, data: 32'h0});
        end
        ad = 16'(int'(cBASE) + i * int'(cSTRIDE) + j);
        exp_q.push_back('{w: 1'b1, addr: ad, data: wv_q.pop_front()});
      end
    end
  endtask

  task automatic run_go(input string tag, input bit exp_sat, input int exp_lat, input bit poke);
    int cyc;
    bit got;
    done_cnt = 0;
    go = 1;
    @(negedge clk);
    go = 0;
    chk({tag, "_busy"}, busy, 1);
    if (poke) begin
      // go while busy with different dimensions must be ignored
      @(negedge clk);
      go = 1; aROWS = 16'd7; bCOLS = 16'd0;
      @(negedge clk);
      go = 0;
    end
    cyc = 0; got = 0;
    while (cyc < 5000 && !got) begin
      @(negedge clk);
      cyc++;
      if (done) got = 1;
    end
    if (!got) fail({tag, "_timeout"}, "done not seen within 5000 cycles");
    else if (exp_lat != 0) chk({tag, "_lat"}, cyc, exp_lat);
    repeat (3) @(negedge clk);
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_sat"}, sat_flag, exp_sat);
    chk({tag, "_all_txn"}, exp_q.size(), 0);
    chk({tag, "_idle"}, busy, 0);
    exp_q.delete();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    rst_n = 0; go = 0;
    cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_status", {busy, done, sat_flag}, 0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    // 2x2 unsigned, no stalls, go poked while busy
    mem[16'h100] = 1; mem[16'h101] = 2; mem[16'h102] = 3; mem[16'h103] = 4;
    mem[16'h200] = 5; mem[16'h201] = 6; mem[16'h202] = 7; mem[16'h203] = 8;
    cfg(16'h100, 16'h200, 16'h300, 2, 2, 2, 2, 2, 2, 0, 0, 0);
    wv_q = '{32'd19, 32'd22, 32'd43, 32'd50};
    push_gemm();
    run_go("mm2x2", 0, 0, 1);

    // signed 1x1x1: -3 * 4
    mem[16'h10] = 32'h0000FFFD; mem[16'h11] = 32'd4;
    cfg(16'h10, 16'h11, 16'h12, 1, 1, 1, 1, 1, 1, 1, 0, 0);
    wv_q = '{32'hFFFFFFF4};
    push_gemm();
    run_go("signed", 0, 0, 0);

    // same data unsigned
    cfg(16'h10, 16'h11, 16'h12, 1, 1, 1, 1, 1, 1, 0, 0, 0);
    wv_q = '{32'h0003FFF4};
    push_gemm();
    run_go("unsigned", 0, 0, 0);

    // accumulate: C=10 + 2*3, C read ahead of A read
    mem[16'h10] = 32'd2; mem[16'h11] = 32'd3; mem[16'h12] = 32'd10;
    cfg(16'h10, 16'h11, 16'h12, 1, 1, 1, 1, 1, 1, 0, 1, 0);
    wv_q = '{32'd16};
    push_gemm();
    run_go("accum", 0, 0, 0);

    // 2x2 again with random grant/rvalid stalls
    stall_en = 1;
    cfg(16'h100, 16'h200, 16'h380, 2, 2, 2, 2, 2, 2, 0, 0, 0);
    wv_q = '{32'd19, 32'd22, 32'd43, 32'd50};
    push_gemm();
    run_go("stall", 0, 0, 0);
    stall_en = 0;

    // 0xFFFF*0xFFFF summed twice = 0x1FFFC0002; >>4 = 0x1FFFC000 fits in 32 bits
    mem[16'h20] = 32'hFFFF; mem[16'h21] = 32'hFFFF; mem[16'h30] = 32'hFFFF; mem[16'h31] = 32'hFFFF;
    cfg(16'h20, 16'h30, 16'h40, 1, 2, 1, 2, 1, 1, 0, 0, 6'd4);
    wv_q = '{32'h1FFFC000};
    push_gemm();
    run_go("shift4", 0, 0, 0);

    // unshifted 0x1FFFC0002 saturates the unsigned range
    cfg(16'h20, 16'h30, 16'h40, 1, 2, 1, 2, 1, 1, 0, 0, 6'd0);
    wv_q = '{32'hFFFFFFFF};
    push_gemm();
    run_go("usat", 1, 0, 0);

    // signed: 2 * (-32768)^2 = 2^31 saturates to signed max
    mem[16'h50] = 32'h8000; mem[16'h51] = 32'h8000; mem[16'h60] = 32'h8000; mem[16'h61] = 32'h8000;
    cfg(16'h50, 16'h60, 16'h70, 1, 2, 1, 2, 1, 1, 1, 0, 6'd0);
    wv_q = '{32'h7FFFFFFF};
    push_gemm();
    run_go("ssat", 1, 0, 0);

    // aCOLS=0 with accumulate: only C reads, shifted writeback, C address wraps 0xFFFF -> 0x0000
    mem[16'hFFFF] = 32'h100; mem[16'h0000] = 32'h25;
    cfg(16'h0, 16'h0, 16'hFFFF, 1, 0, 2, 1, 1, 1, 0, 1, 6'd4);
    wv_q = '{32'h10, 32'h2};
    push_gemm();
    run_go("k0_wrap", 0, 0, 0);

    // bCOLS=0: rows are walked but nothing is read or written
    cfg(16'h100, 16'h200, 16'h300, 2, 2, 0, 2, 2, 2, 0, 0, 0);
    run_go("n0", 0, 0, 0);

    // reset while the B read is outstanding
    cfg(16'h100, 16'h200, 16'h300, 2, 2, 2, 2, 2, 2, 0, 0, 0);
    exp_q.push_back('{w: 1'b0, addr: 16'h100, data: 32'h0});
    exp_q.push_back('{w: 1'b0, addr: 16'h200, data: 32'h0});
    n_rd = 0;
    go = 1;
    @(negedge clk);
    go = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (n_rd >= 2) break;
    end
    if (n_rd < 2) fail("abort_wait", "B read never granted");
    rst_n = 0;
    #1;
    chk("abort_mem_req", mem_req, 0);
    chk("abort_busy", busy, 0);
    repeat (2) @(negedge clk);
    chk("abort_reads", exp_q.size(), 0);
    exp_q.delete();
    rst_n = 1;
    repeat (4) @(negedge clk);
    chk("abort_status", {busy, done, mem_req}, 0);

    // aROWS=0 after reset: done two cycles after go is taken, no transactions
    cfg(16'h100, 16'h200, 16'h300, 0, 2, 2, 2, 2, 2, 0, 0, 0);
    run_go("m0", 0, 2, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
